// File: rtl/cond_flag_unit_if.sv
// Handshake bundle between the execute-stage decoder and cond_flag_unit.
// Decoder side uses master, the flag unit uses slave.
interface cond_flag_unit_if #(
    parameter int COND_W      = 4,
    parameter int STACK_DEPTH = 4
);
    localparam int LW = $clog2(STACK_DEPTH + 1);

    logic [1:0]        ALUFlags;
    logic              FlagWrite;
    logic [COND_W-1:0] Cond;
    logic              flag_push;
    logic              flag_pop;
    logic              err_clr;

    logic              CondEx;
    logic [1:0]        Flags;
    logic [LW-1:0]     stack_level;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    modport master (
        output ALUFlags, FlagWrite, Cond,
        output flag_push, flag_pop, err_clr,
        input  CondEx, Flags, stack_level,
        input  stack_full, stack_empty, stack_err
    );

    modport slave (
        input  ALUFlags, FlagWrite, Cond,
        input  flag_push, flag_pop, err_clr,
        output CondEx, Flags, stack_level,
        output stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/cond_flag_unit.sv
// Architectural {V,Z} flag register with condition evaluation.
// Define FLAG_STACK_EN to build the interrupt save/restore flag stack.
module cond_flag_unit #(
    parameter int COND_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cond_flag_unit_if.slave       bus
);
    localparam int LW = $clog2(STACK_DEPTH + 1);

    logic [1:0] flags_q, flags_d;
    logic       cond_ex;
    logic       v_f, z_f;

    assign v_f = flags_q[1];
    assign z_f = flags_q[0];

    // Decode looks only at the stored flags; codes 8 and above are reserved.
    always_comb begin
        cond_ex = 1'b0;
        if ((bus.Cond >> 3) == '0) begin
            unique case (bus.Cond[2:0])
                3'd0: cond_ex = z_f;
                3'd1: cond_ex = ~z_f;
                3'd2: cond_ex = v_f;
                3'd3: cond_ex = ~v_f;
                3'd4: cond_ex = 1'b1;
                3'd5: cond_ex = 1'b0;
                3'd6: cond_ex = z_f | v_f;
                3'd7: cond_ex = ~z_f & ~v_f;
            endcase
        end
    end

    assign bus.CondEx = cond_ex;
    assign bus.Flags  = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= 2'b00;
        else        flags_q <= flags_d;
    end

`ifdef FLAG_STACK_EN
    localparam int IW = $clog2(STACK_DEPTH);

    logic [1:0]    stack_q [STACK_DEPTH];
    logic [1:0]    stack_d [STACK_DEPTH];
    logic [LW-1:0] level_q, level_d;
    logic          err_q, err_d;
    logic          full, empty;
    logic [IW-1:0] top_idx, wr_idx;

    assign full    = (level_q == LW'(STACK_DEPTH));
    assign empty   = (level_q == '0);
    assign top_idx = IW'(level_q - 1'b1);
    assign wr_idx  = IW'(level_q);

    always_comb begin
        flags_d = flags_q;
        level_d = level_q;
        stack_d = stack_q;
        err_d   = err_q & ~bus.err_clr;
        if (bus.FlagWrite && cond_ex)
            flags_d = bus.ALUFlags;
        // A successful pop overrides any flag write in the same cycle.
        if (bus.flag_push && bus.flag_pop) begin
            err_d = 1'b1;
        end else if (bus.flag_pop) begin
            if (!empty) begin
                flags_d = stack_q[top_idx];
                level_d = level_q - 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.flag_push) begin
            if (!full) begin
                stack_d[wr_idx] = flags_q;
                level_d = level_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign bus.stack_level = level_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = err_q;
`else
    logic unused_stack_in;

    assign unused_stack_in = ^{bus.flag_push, bus.flag_pop, bus.err_clr};

    always_comb begin
        flags_d = flags_q;
        if (bus.FlagWrite && cond_ex)
            flags_d = bus.ALUFlags;
    end

    assign bus.stack_level = '0;
    assign bus.stack_full  = 1'b0;
    assign bus.stack_empty = 1'b1;
    assign bus.stack_err   = 1'b0;
`endif
endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: decode table, gated flag writes
// and, when FLAG_STACK_EN is defined, stack bounds and conflicts.
module tb_cond_flag_unit;
    localparam int COND_W = 4;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] tbl [4];

    cond_flag_unit_if #(.COND_W(COND_W), .STACK_DEPTH(DEPTH)) bus ();

    cond_flag_unit #(.COND_W(COND_W), .STACK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.FlagWrite = 1'b0;
        bus.flag_push = 1'b0;
        bus.flag_pop  = 1'b0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic set_flags(input logic [1:0] f);
        bus.Cond      = 4'b0100;
        bus.FlagWrite = 1'b1;
        bus.ALUFlags  = f;
        tick();
        bus.FlagWrite = 1'b0;
    endtask

    task automatic chk_stack(input string tag, input logic [1:0] fl,
                             input int lvl, input logic full,
                             input logic empty, input logic err);
        chk({tag, "_flags"}, 8'(bus.Flags), 8'(fl));
        chk({tag, "_level"}, 8'(bus.stack_level), 8'(lvl));
        chk({tag, "_full"},  8'(bus.stack_full), 8'(full));
        chk({tag, "_empty"}, 8'(bus.stack_empty), 8'(empty));
        chk({tag, "_err"},   8'(bus.stack_err), 8'(err));
    endtask

    initial begin
        // Expected CondEx for Cond 0..7, bit i = code i, per {V,Z}.
        tbl[0] = 8'h9A;
        tbl[1] = 8'h59;
        tbl[2] = 8'h56;
        tbl[3] = 8'h55;
        bus.ALUFlags = 2'b00;
        bus.Cond     = 4'b0000;
        idle();

        // T1: asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        bus.Cond = 4'b0001;
        #1;
        chk("t1_flags", 8'(bus.Flags), 8'h00);
        chk("t1_level", 8'(bus.stack_level), 8'h00);
        chk("t1_err",   8'(bus.stack_err), 8'h00);
        chk("t1_empty", 8'(bus.stack_empty), 8'h01);
        chk("t1_condex_ne", 8'(bus.CondEx), 8'h01);
        #1 rst_n = 1'b1;
        tick();

        // T2: write gated by failing condition, then AL write
        bus.Cond      = 4'b0000;
        bus.FlagWrite = 1'b1;
        bus.ALUFlags  = 2'b01;
        #1;
        chk("t2_condex_eq0", 8'(bus.CondEx), 8'h00);
        tick();
        chk("t2_gated", 8'(bus.Flags), 8'h00);
        bus.Cond = 4'b0100;
        #1;
        chk("t2_nobypass", 8'(bus.Flags), 8'h00);
        tick();
        bus.FlagWrite = 1'b0;
        chk("t2_written", 8'(bus.Flags), 8'h01);
        bus.Cond = 4'b0000;
        #1;
        chk("t2_condex_eq1", 8'(bus.CondEx), 8'h01);

        // T3: decode sweep over all flag values and condition codes
        for (int f = 0; f < 4; f++) begin
            set_flags(2'(f));
            chk($sformatf("t3_flags%0d", f), 8'(bus.Flags), 8'(f));
            for (int c = 0; c < 16; c++) begin
                logic [7:0] row;
                logic [3:0] cc;
                logic       e;
                row = tbl[f[1:0]];
                cc  = 4'(c);
                e   = cc[3] ? 1'b0 : row[cc[2:0]];
                bus.Cond = cc;
                #1;
                chk($sformatf("t3_f%0d_c%0d", f, c), 8'(bus.CondEx), 8'(e));
            end
        end

`ifdef FLAG_STACK_EN
        // T4: push saves pre-update flags while FlagWrite updates
        set_flags(2'b10);
        bus.flag_push = 1'b1;
        bus.FlagWrite = 1'b1;
        bus.Cond      = 4'b0100;
        bus.ALUFlags  = 2'b01;
        tick();
        idle();
        chk_stack("t4_push", 2'b01, 1, 1'b0, 1'b0, 1'b0);
        bus.flag_pop = 1'b1;
        tick();
        idle();
        chk_stack("t4_pop", 2'b10, 0, 1'b0, 1'b1, 1'b0);

        // T5: five pushes, saving 10,11,00,01; fifth overflows
        bus.flag_push = 1'b1;
        bus.FlagWrite = 1'b1;
        bus.Cond      = 4'b0100;
        bus.ALUFlags  = 2'b11; tick();
        bus.ALUFlags  = 2'b00; tick();
        bus.ALUFlags  = 2'b01; tick();
        bus.ALUFlags  = 2'b10; tick();
        chk_stack("t5_four", 2'b10, 4, 1'b1, 1'b0, 1'b0);
        bus.ALUFlags  = 2'b11; tick();
        idle();
        chk_stack("t5_over", 2'b11, 4, 1'b1, 1'b0, 1'b1);
        bus.err_clr = 1'b1;
        tick();
        idle();
        chk("t5_errclr", 8'(bus.stack_err), 8'h00);
        bus.flag_pop = 1'b1;
        tick();
        chk_stack("t5_pop1", 2'b01, 3, 1'b0, 1'b0, 1'b0);
        tick();
        chk_stack("t5_pop2", 2'b00, 2, 1'b0, 1'b0, 1'b0);
        tick();
        chk_stack("t5_pop3", 2'b11, 1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_stack("t5_pop4", 2'b10, 0, 1'b0, 1'b1, 1'b0);
        // Underflow: write applies, and a new error beats err_clr
        bus.FlagWrite = 1'b1;
        bus.Cond      = 4'b0100;
        bus.ALUFlags  = 2'b01;
        bus.err_clr   = 1'b1;
        tick();
        idle();
        chk_stack("t5_under", 2'b01, 0, 1'b0, 1'b1, 1'b1);
        bus.err_clr = 1'b1;
        tick();
        idle();
        chk("t5_errclr2", 8'(bus.stack_err), 8'h00);

        // T6: push&pop conflict, then pop overriding FlagWrite
        bus.flag_push = 1'b1;
        tick();
        idle();
        chk_stack("t6_push", 2'b01, 1, 1'b0, 1'b0, 1'b0);
        bus.flag_push = 1'b1;
        bus.flag_pop  = 1'b1;
        bus.FlagWrite = 1'b1;
        bus.Cond      = 4'b0100;
        bus.ALUFlags  = 2'b11;
        tick();
        idle();
        chk_stack("t6_both", 2'b11, 1, 1'b0, 1'b0, 1'b1);
        bus.err_clr = 1'b1;
        tick();
        idle();
        bus.flag_pop  = 1'b1;
        bus.FlagWrite = 1'b1;
        bus.ALUFlags  = 2'b00;
        tick();
        idle();
        chk_stack("t6_popwin", 2'b01, 0, 1'b0, 1'b1, 1'b0);

        // Async reset with occupied stack discards everything
        set_flags(2'b11);
        bus.flag_push = 1'b1;
        tick();
        idle();
        chk("t7_pre_level", 8'(bus.stack_level), 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk_stack("t7_reset", 2'b00, 0, 1'b0, 1'b1, 1'b0);
        #1 rst_n = 1'b1;
        tick();
`else
        // Stack disabled: stack controls never disturb stack outputs
        set_flags(2'b10);
        bus.flag_push = 1'b1;
        bus.FlagWrite = 1'b1;
        bus.Cond      = 4'b0100;
        bus.ALUFlags  = 2'b01;
        tick();
        idle();
        chk_stack("t6_nopush", 2'b01, 0, 1'b0, 1'b1, 1'b0);
        bus.flag_pop = 1'b1;
        tick();
        idle();
        chk_stack("t6_nopop", 2'b01, 0, 1'b0, 1'b1, 1'b0);
        bus.flag_push = 1'b1;
        bus.flag_pop  = 1'b1;
        bus.err_clr   = 1'b1;
        bus.FlagWrite = 1'b1;
        bus.ALUFlags  = 2'b11;
        tick();
        idle();
        chk_stack("t6_noboth", 2'b11, 0, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_stack("t7_reset", 2'b00, 0, 1'b0, 1'b1, 1'b0);
        #1 rst_n = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
